// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch/redirect unit.
//   XLEN      - default address/instruction width
//   RESET_PC  - default first fetch address after reset
//   PC_INC    - sequential fetch stride in bytes
//   fetch_state_e - fetch controller states
package fetch_redirect_unit_pkg;
  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int              PC_INC   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DISCARD
  } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding an instruction fetched while IF/ID was
// stalled.
//   clk, rst_n     - clock, async active-low reset
//   load_i         - capture data_i/pc_i and mark valid
//   clear_i        - invalidate the entry (wins over load_i)
//   data_i, pc_i   - instruction and its address
//   valid_o, data_o, pc_o - stored entry
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o,
  output logic [XLEN-1:0] pc_o
);
  logic            valid_q;
  logic [XLEN-1:0] data_q, pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction fetch controller with branch redirect handling.
// Keeps at most one instruction-memory request outstanding, fills the IF/ID
// register, parks a response in a skid buffer when IF/ID is stalled, and
// drops in-flight responses made stale by a redirect.
//   clk, rst_n                 - clock, async active-low reset
//   switch_branch, branch_target - redirect request and address
//   stall                      - hold IF/ID
//   imem_req, imem_addr        - memory request
//   imem_ack, imem_rdata       - memory response
//   ifid_valid/instr/pc        - IF/ID pipeline register
//   flush_idex                 - one-cycle squash of ID/EX after a redirect
module fetch_redirect_unit #(
  parameter int              XLEN     = fetch_redirect_unit_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_redirect_unit_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            switch_branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic            flush_idex
);
  import fetch_redirect_unit_pkg::*;

  localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;             // next address to fetch
  logic [XLEN-1:0] req_addr_q, req_addr_d; // address of the live request
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic            flush_q;

  logic            skid_load, skid_clear, skid_valid;
  logic [XLEN-1:0] skid_data, skid_pc;
  logic [XLEN-1:0] tgt, pc_inc;

  assign tgt    = {branch_target[XLEN-1:2], 2'b00};
  assign pc_inc = req_addr_q + INC;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;

    if (switch_branch) begin
      // Redirect beats stall and ack. An unacked request cannot be
      // cancelled, so it is drained in DISCARD before the target is fetched.
      pc_d         = tgt;
      ifid_valid_d = 1'b0;
      skid_clear   = 1'b1;
      case (state_q)
        S_FETCH, S_DISCARD: begin
          if (imem_ack) begin
            state_d    = S_FETCH;
            req_addr_d = tgt;
          end else begin
            state_d = S_DISCARD;
          end
        end
        default: begin
          state_d    = S_FETCH;
          req_addr_d = tgt;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!stall) begin
            state_d    = S_FETCH;
            req_addr_d = pc_q;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            pc_d = pc_inc;
            if (stall) begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
            end else begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem_rdata;
              ifid_pc_d    = req_addr_q;
              req_addr_d   = pc_inc;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_valid_d = skid_valid;
            ifid_instr_d = skid_data;
            ifid_pc_d    = skid_pc;
            skid_clear   = 1'b1;
            state_d      = S_FETCH;
            req_addr_d   = pc_q;
          end
        end
        S_DISCARD: begin
          if (imem_ack) begin
            state_d    = S_FETCH;
            req_addr_d = pc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      flush_q      <= switch_branch;
    end
  end

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (imem_rdata),
    .pc_i    (req_addr_q),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .pc_o    (skid_pc)
  );

  // Request is a pure decode of the state register; DISCARD keeps the old
  // request alive until memory answers it.
  assign imem_req   = (state_q == S_FETCH) || (state_q == S_DISCARD);
  assign imem_addr  = req_addr_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign flush_idex = flush_q;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: sequential fetch, stall/skid,
// redirect with and without ack, back-to-back redirects, mid-request reset.
module tb_fetch_redirect_unit;
  logic        clk, rst_n;
  logic        switch_branch, stall, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, ifid_valid, flush_idex;
  logic [31:0] imem_addr, ifid_instr, ifid_pc;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  fetch_redirect_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .switch_branch (switch_branch),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .flush_idex    (flush_idex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; switch_branch = 1'b0; branch_target = '0;
    stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

    tick();
    chk("rst_req",   32'(imem_req),   32'd0);
    chk("rst_addr",  imem_addr,       32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_instr", ifid_instr,      32'h0);
    chk("rst_pc",    ifid_pc,         32'h0);
    chk("rst_flush", 32'(flush_idex), 32'd0);
    rst_n = 1'b1;

    // Sequential fetch, ack every cycle
    tick();
    chk("seq0_req",  32'(imem_req), 32'd1);
    chk("seq0_addr", imem_addr,     32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
    tick();
    chk("seq1_addr",  imem_addr,       32'h4);
    chk("seq1_valid", 32'(ifid_valid), 32'd1);
    chk("seq1_pc",    ifid_pc,         32'h0);
    chk("seq1_instr", ifid_instr,      32'h1111_0000);
    imem_rdata = 32'h1111_0004;
    tick();
    chk("seq2_addr", imem_addr, 32'h8);
    chk("seq2_pc",   ifid_pc,   32'h4);

    // Ack at 0x8 under stall, stall held 3 cycles
    imem_rdata = 32'h1111_0008; stall = 1'b1;
    tick();
    chk("hold1_req", 32'(imem_req), 32'd0);
    chk("hold1_pc",  ifid_pc,       32'h4);
    imem_ack = 1'b0;
    tick();
    chk("hold2_req", 32'(imem_req), 32'd0);
    tick();
    chk("hold3_req", 32'(imem_req), 32'd0);
    chk("hold3_pc",  ifid_pc,       32'h4);
    stall = 1'b0;
    tick();
    chk("unhold_pc",    ifid_pc,         32'h8);
    chk("unhold_instr", ifid_instr,      32'h1111_0008);
    chk("unhold_valid", 32'(ifid_valid), 32'd1);
    chk("unhold_req",   32'(imem_req),   32'd1);
    chk("unhold_addr",  imem_addr,       32'hC);
    imem_ack = 1'b1; imem_rdata = 32'h1111_000C;
    tick();
    chk("c_pc",   ifid_pc,   32'hC);
    chk("c_addr", imem_addr, 32'h10);

    // Redirect to 0x103 while 0x10 unacked -> DISCARD
    imem_ack = 1'b0; switch_branch = 1'b1; branch_target = 32'h103;
    tick();
    chk("disc_req",   32'(imem_req),   32'd1);
    chk("disc_addr",  imem_addr,       32'h10);
    chk("disc_flush", 32'(flush_idex), 32'd1);
    chk("disc_valid", 32'(ifid_valid), 32'd0);
    switch_branch = 1'b0;
    tick();
    chk("disc2_flush", 32'(flush_idex), 32'd0);
    chk("disc2_addr",  imem_addr,       32'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0010;
    tick();
    chk("tgt_addr",  imem_addr,       32'h100);
    chk("tgt_valid", 32'(ifid_valid), 32'd0);
    imem_rdata = 32'h2222_0100;
    tick();
    chk("tgt_pc",    ifid_pc,    32'h100);
    chk("tgt_instr", ifid_instr, 32'h2222_0100);
    chk("tgt_next",  imem_addr,  32'h104);

    // Redirect on the same edge as ack with stall -> no HOLD
    stall = 1'b1; switch_branch = 1'b1; branch_target = 32'h200;
    imem_rdata = 32'h2222_0104;
    tick();
    chk("rack_req",   32'(imem_req),   32'd1);
    chk("rack_addr",  imem_addr,       32'h200);
    chk("rack_valid", 32'(ifid_valid), 32'd0);
    chk("rack_flush", 32'(flush_idex), 32'd1);
    switch_branch = 1'b0; stall = 1'b0; imem_rdata = 32'h3333_0200;
    tick();
    chk("r200_pc",    ifid_pc,         32'h200);
    chk("r200_instr", ifid_instr,      32'h3333_0200);
    chk("r200_addr",  imem_addr,       32'h204);
    chk("r200_flush", 32'(flush_idex), 32'd0);

    // Two consecutive redirects
    imem_ack = 1'b0; switch_branch = 1'b1; branch_target = 32'h300;
    tick();
    chk("bb1_flush", 32'(flush_idex), 32'd1);
    chk("bb1_addr",  imem_addr,       32'h204);
    branch_target = 32'h400;
    tick();
    chk("bb2_flush", 32'(flush_idex), 32'd1);
    chk("bb2_addr",  imem_addr,       32'h204);
    switch_branch = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_0204;
    tick();
    chk("bb3_flush", 32'(flush_idex), 32'd0);
    chk("bb3_addr",  imem_addr,       32'h400);
    chk("bb3_valid", 32'(ifid_valid), 32'd0);
    imem_rdata = 32'h4444_0400;
    tick();
    chk("bb4_pc",    ifid_pc,         32'h400);
    chk("bb4_valid", 32'(ifid_valid), 32'd1);
    chk("bb4_addr",  imem_addr,       32'h404);

    // No ack, no stall -> bubble
    imem_ack = 1'b0;
    tick();
    chk("bub_valid", 32'(ifid_valid), 32'd0);
    chk("bub_pc",    ifid_pc,         32'h400);
    chk("bub_addr",  imem_addr,       32'h404);

    // Reset mid-request, then a late ack
    #2 rst_n = 1'b0; stall = 1'b1;
    #1;
    chk("mrst_req",   32'(imem_req),   32'd0);
    chk("mrst_addr",  imem_addr,       32'h0);
    chk("mrst_pc",    ifid_pc,         32'h0);
    chk("mrst_instr", ifid_instr,      32'h0);
    chk("mrst_flush", 32'(flush_idex), 32'd0);
    #1 rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    chk("late_req",   32'(imem_req),   32'd0);
    chk("late_valid", 32'(ifid_valid), 32'd0);
    chk("late_instr", ifid_instr,      32'h0);
    stall = 1'b0; imem_ack = 1'b0;
    tick();
    chk("restart_req",  32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr,     32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
